// File: rtl/mldsa_run_ctrl.sv
// mldsa_run_ctrl: ML-DSA run sequencer (launch, sign retry, timeout, status).
// Optional macro MLDSA_IRQ_EN adds a sticky completion interrupt on irq.
module mldsa_run_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
    parameter logic [7:0]  MAX_REJECT     = 8'd64,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_pulse,
    input  logic [1:0]       main_mode,
    input  logic             clr_status,
    input  logic             core_done,
    input  logic             core_reject,
    output logic             core_start,
    output logic             core_abort,
    output logic [1:0]       core_mode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [7:0]       rej_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             irq
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        FINISH,
        FAIL
    } state_t;

    state_t             state, state_n;
    logic [23:0]        tmr, tmr_n;
    logic [1:0]         mode_n;
    logic               done_n, err_n;
    logic [1:0]         code_n;
    logic [7:0]         rej_n;
    logic [CNT_W-1:0]   cyc_n;
    logic               start_n, abort_n, busy_n;
    logic               clr_req;

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        mode_n  = core_mode;
        done_n  = done;
        err_n   = err;
        code_n  = err_code;
        rej_n   = rej_count;
        cyc_n   = cycle_count;
        abort_n = 1'b0;
        clr_req = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    mode_n  = main_mode;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    code_n  = 2'd0;
                    rej_n   = 8'd0;
                    cyc_n   = '0;
                    clr_req = 1'b1;
                    if (main_mode == 2'd3) begin
                        state_n = FAIL;
                        code_n  = 2'd1;
                    end else begin
                        state_n = LAUNCH;
                    end
                end else if (clr_status) begin
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    code_n  = 2'd0;
                    clr_req = 1'b1;
                end
            end
            LAUNCH: begin
                tmr_n   = 24'd0;
                state_n = RUN;
            end
            RUN: begin
                tmr_n = tmr + 24'd1;
                if (cycle_count != '1) begin
                    cyc_n = cycle_count + 1'b1;
                end
                if (core_done) begin
                    if (core_reject && core_mode == 2'd1) begin
                        rej_n = rej_count + 8'd1;
                        if (rej_n == MAX_REJECT) begin
                            state_n = FAIL;
                            code_n  = 2'd2;
                        end else begin
                            state_n = LAUNCH;
                        end
                    end else begin
                        state_n = FINISH;
                    end
                end else if (tmr == TIMEOUT_CYCLES - 24'd1) begin
                    abort_n = 1'b1;
                    state_n = FAIL;
                    code_n  = 2'd3;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            FAIL: begin
                err_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        start_n = (state == LAUNCH);
        busy_n  = (state_n == LAUNCH) || (state_n == RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            tmr         <= 24'd0;
            core_mode   <= 2'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'd0;
            rej_count   <= 8'd0;
            cycle_count <= '0;
            core_start  <= 1'b0;
            core_abort  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            tmr         <= tmr_n;
            core_mode   <= mode_n;
            done        <= done_n;
            err         <= err_n;
            err_code    <= code_n;
            rej_count   <= rej_n;
            cycle_count <= cyc_n;
            core_start  <= start_n;
            core_abort  <= abort_n;
            busy        <= busy_n;
        end
    end

`ifdef MLDSA_IRQ_EN
    logic irq_q;

    // Interrupt level: set entering FINISH/FAIL, cleared by clear or new start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_q <= 1'b0;
        end else if (state != state_n &&
                     (state_n == FINISH || state_n == FAIL)) begin
            irq_q <= 1'b1;
        end else if (clr_req) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mldsa_run_ctrl.sv
// tb_mldsa_run_ctrl: directed self-checking bench for mldsa_run_ctrl.
// DUT built with TIMEOUT_CYCLES=16 and MAX_REJECT=4.
module tb_mldsa_run_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_pulse;
    logic [1:0]  main_mode;
    logic        clr_status;
    logic        core_done;
    logic        core_reject;
    logic        core_start;
    logic        core_abort;
    logic [1:0]  core_mode;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  rej_count;
    logic [31:0] cycle_count;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int n_abort  = 0;

`ifdef MLDSA_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    mldsa_run_ctrl #(
        .TIMEOUT_CYCLES(24'd16),
        .MAX_REJECT    (8'd4),
        .CNT_W         (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_pulse(start_pulse),
        .main_mode  (main_mode),
        .clr_status (clr_status),
        .core_done  (core_done),
        .core_reject(core_reject),
        .core_start (core_start),
        .core_abort (core_abort),
        .core_mode  (core_mode),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .rej_count  (rej_count),
        .cycle_count(cycle_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (core_start === 1'b1) n_start++;
        if (core_abort === 1'b1) n_abort++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic kick(input logic [1:0] m);
        main_mode   = m;
        start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
    endtask

    // which: 0 = core_start, 1 = core_abort; n = -1 when budget expires
    task automatic wait_for(input int which, input int max, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < max) begin
            i++;
            step();
            if ((which == 0 && core_start === 1'b1) ||
                (which == 1 && core_abort === 1'b1))
                n = i;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start_pulse = 1'b0; main_mode = 2'd0;
        clr_status = 1'b0; core_done = 1'b0; core_reject = 1'b0;
        step(); step();
        checks++;
        if ({core_start, core_abort, busy, done, err, err_code, rej_count,
             cycle_count, core_mode, irq} !== 51'd0) begin
            failures++;
            $display("FAIL rst_outputs got=%0h exp=0",
                {core_start, core_abort, busy, done, err, err_code,
                 rej_count, cycle_count, core_mode, irq});
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_keygen();
        int n;
        n_start = 0;
        kick(2'd0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL kg_busy_launch got=%0d exp=1", busy); end
        wait_for(0, 8, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL kg_start_lat got=%0d exp=1", n); end
        repeat (10) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL kg_done_early got=%0d exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kg_busy_finish got=%0d exp=0", busy); end
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL kg_done got=%0d exp=1", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL kg_err got=%0d exp=0", err); end
        checks++; if (cycle_count !== 32'd11) begin failures++; $display("FAIL kg_cycles got=%0d exp=11", cycle_count); end
        checks++; if (n_start !== 1) begin failures++; $display("FAIL kg_nstart got=%0d exp=1", n_start); end
        checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL kg_irq got=%0d exp=%0d", irq, IRQ_EN); end
    endtask

    task automatic test_sign_reject();
        int n;
        n_start = 0;
        kick(2'd1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL sg_done_clr got=%0d exp=0", done); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL sg_irq_clr got=%0d exp=0", irq); end
        wait_for(0, 8, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL sg_start_lat got=%0d exp=1", n); end
        for (int r = 0; r < 3; r++) begin
            repeat (2) step();
            core_done = 1'b1; core_reject = 1'b1;
            step();
            core_reject = 1'b0;
            step();
            core_done = 1'b0;
            checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL sg_rej_lat r=%0d got=%0d exp=1", r, core_start); end
            checks++; if (rej_count !== 8'(r + 1)) begin failures++; $display("FAIL sg_rej_cnt got=%0d exp=%0d", rej_count, r + 1); end
        end
        step();
        core_reject = 1'b1;
        step();
        core_reject = 1'b0;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL sg_done got=%0d exp=1", done); end
        checks++; if (rej_count !== 8'd3) begin failures++; $display("FAIL sg_rej_final got=%0d exp=3", rej_count); end
        checks++; if (n_start !== 4) begin failures++; $display("FAIL sg_nstart got=%0d exp=4", n_start); end
        checks++; if ({err, err_code} !== 3'd0) begin failures++; $display("FAIL sg_err got=%0d exp=0", {err, err_code}); end
    endtask

    task automatic test_reject_limit();
        int n;
        n_start = 0;
        kick(2'd1);
        for (int r = 0; r < 4; r++) begin
            wait_for(0, 8, n);
            checks++; if (n !== 1) begin failures++; $display("FAIL rl_start r=%0d got=%0d exp=1", r, n); end
            step();
            core_done = 1'b1; core_reject = 1'b1;
            step();
            core_done = 1'b0; core_reject = 1'b0;
        end
        checks++; if (err_code !== 2'd2) begin failures++; $display("FAIL rl_code got=%0d exp=2", err_code); end
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rl_err got=%0d exp=1", err); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rl_done got=%0d exp=0", done); end
        checks++; if (rej_count !== 8'd4) begin failures++; $display("FAIL rl_rej got=%0d exp=4", rej_count); end
        checks++; if (n_start !== 4) begin failures++; $display("FAIL rl_nstart got=%0d exp=4", n_start); end
        checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL rl_irq got=%0d exp=%0d", irq, IRQ_EN); end
    endtask

    task automatic test_timeout();
        int n;
        n_abort = 0;
        kick(2'd2);
        wait_for(0, 8, n);
        repeat (15) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL to_done_wins got=%0d exp=1", done); end
        checks++; if (n_abort !== 0) begin failures++; $display("FAIL to_no_abort got=%0d exp=0", n_abort); end
        kick(2'd2);
        wait_for(0, 8, n);
        wait_for(1, 40, n);
        checks++; if (n !== 16) begin failures++; $display("FAIL to_abort_lat got=%0d exp=16", n); end
        checks++; if (err_code !== 2'd3) begin failures++; $display("FAIL to_code got=%0d exp=3", err_code); end
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%0d exp=1", err); end
        checks++; if (n_abort !== 1) begin failures++; $display("FAIL to_nabort got=%0d exp=1", n_abort); end
        checks++; if (irq !== IRQ_EN) begin failures++; $display("FAIL to_irq got=%0d exp=%0d", irq, IRQ_EN); end
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        checks++; if ({err, err_code, irq} !== 4'd0) begin failures++; $display("FAIL to_clr got=%0h exp=0", {err, err_code, irq}); end
    endtask

    task automatic test_bad_mode();
        int n;
        n_start = 0;
        kick(2'd3);
        checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL bm_code got=%0d exp=1", err_code); end
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bm_err got=%0d exp=1", err); end
        checks++; if (core_mode !== 2'd3) begin failures++; $display("FAIL bm_mode got=%0d exp=3", core_mode); end
        repeat (3) step();
        checks++; if (n_start !== 0) begin failures++; $display("FAIL bm_nstart got=%0d exp=0", n_start); end
        kick(2'd2);
        wait_for(0, 8, n);
        main_mode = 2'd0; start_pulse = 1'b1;
        step();
        start_pulse = 1'b0;
        checks++; if (core_mode !== 2'd2) begin failures++; $display("FAIL ov_mode got=%0d exp=2", core_mode); end
        repeat (2) step();
        core_done = 1'b1; core_reject = 1'b1;
        step();
        core_done = 1'b0; core_reject = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ov_done got=%0d exp=1", done); end
        checks++; if (rej_count !== 8'd0) begin failures++; $display("FAIL ov_rej got=%0d exp=0", rej_count); end
        checks++; if (n_start !== 1) begin failures++; $display("FAIL ov_nstart got=%0d exp=1", n_start); end
    endtask

    task automatic test_reset_midrun();
        int n;
        n_abort = 0;
        kick(2'd1);
        wait_for(0, 8, n);
        repeat (3) step();
        resetn = 1'b0;
        #1;
        checks++;
        if ({core_start, core_abort, busy, done, err, err_code, rej_count,
             cycle_count, core_mode, irq} !== 51'd0) begin
            failures++;
            $display("FAIL mr_outputs got=%0h exp=0",
                {core_start, core_abort, busy, done, err, err_code,
                 rej_count, cycle_count, core_mode, irq});
        end
        step();
        resetn = 1'b1;
        step();
        checks++; if (n_abort !== 0) begin failures++; $display("FAIL mr_abort got=%0d exp=0", n_abort); end
        kick(2'd0);
        wait_for(0, 8, n);
        checks++; if (n !== 1) begin failures++; $display("FAIL mr_restart got=%0d exp=1", n); end
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL mr_done got=%0d exp=1", done); end
        checks++; if (cycle_count !== 32'd2) begin failures++; $display("FAIL mr_cycles got=%0d exp=2", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_keygen();
        test_sign_reject();
        test_reject_limit();
        test_timeout();
        test_bad_mode();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mldsa_run_ctrl.md
Name: mldsa_run_ctrl

Overview:
Run sequencer directly downstream of the AXI4-Lite control slave. It consumes main_mode and start_pulse, launches the ML-DSA core, and restarts the core on sign-mode rejections. It guards each run with a timeout and returns busy/done/error status and cycle count for the slave's read-back path.

Parameters:
TIMEOUT_CYCLES, 24'd16777215, max RUN cycles per attempt before abort; must be >= 2
MAX_REJECT, 8'd64, max sign-mode rejection restarts before error; must be >= 1
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start_pulse  in  1  1-cycle start request from control slave
main_mode  in  2  0=keygen, 1=sign, 2=verify, 3=reserved
clr_status  in  1  clears done/err/err_code; honoured only in IDLE
core_done  in  1  1-cycle completion pulse from core
core_reject  in  1  qualifies core_done: sign attempt rejected, retry needed
core_start  out  1  1-cycle launch pulse to core
core_abort  out  1  1-cycle abort pulse to core on timeout
core_mode  out  2  mode latched at accepted start
busy  out  1  high in LAUNCH and RUN
done  out  1  sticky: last run completed OK
err  out  1  sticky: last run failed
err_code  out  2  0=none, 1=bad mode, 2=reject limit, 3=timeout
rej_count  out  8  rejections in current/last run
cycle_count  out  CNT_W  cycles spent in RUN across all attempts of current/last run, saturating
irq  out  1  see Optional Feature

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0, including core_mode, counters and err_code. Reset mid-run drops the run silently. core_abort is not pulsed.
- States: IDLE, LAUNCH, RUN, FINISH, FAIL.
- IDLE, start_pulse=1:
  - Latch core_mode=main_mode.
  - Clear done, err, err_code, rej_count and cycle_count.
  - mode 3 -> FAIL with err_code=1. Otherwise -> LAUNCH.
- IDLE, clr_status=1 without start: clear done, err and err_code next cycle. If start and clr occur in the same cycle, start wins; the result is identical.
- start_pulse outside IDLE: ignored, with no effect on any output.
- LAUNCH: core_start=1 for exactly this cycle; reset the per-attempt timer; -> RUN. A core_done arriving in LAUNCH is ignored.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones. The per-attempt timer increments each cycle.
  - core_done=1 with core_reject=1 and core_mode==1: rej_count+1. If the new rej_count == MAX_REJECT -> FAIL with err_code=2. Otherwise -> LAUNCH, which re-pulses core_start.
  - core_done=1 otherwise: -> FINISH. core_reject is ignored for keygen/verify.
  - core_reject without core_done: ignored.
  - Per-attempt timer reaching TIMEOUT_CYCLES-1 with no core_done: core_abort=1 for 1 cycle; -> FAIL with err_code=3.
  - core_done and timeout in the same cycle: done wins.
- FINISH (1 cycle): done<=1; -> IDLE.
- FAIL (1 cycle): err<=1; -> IDLE.
- Latency:
  - start_pulse to core_start: 2 cycles.
  - core_done to done visible: 2 cycles.
  - Rejection to next core_start: 2 cycles.
- All outputs are registered. core_start and core_abort are never high simultaneously.

Optional Feature:
MLDSA_IRQ_EN
- Defined: irq is a registered level, set on entry to FINISH or FAIL. It clears on clr_status in IDLE or on an accepted start_pulse.
- Undefined: irq is tied 0 and no interrupt logic is generated. All other behaviour is unchanged.

Test Plan:
- Keygen nominal: main_mode=0, start_pulse; core_done 10 cycles after core_start -> core_start 2 cycles after start; done=1, err=0, cycle_count=10 (+/-1 per defined counting edge), busy low after FINISH.
- Sign with 3 rejections (MAX_REJECT=64): mode=1, three core_done+core_reject, then plain core_done -> 4 core_start pulses, rej_count=3, done=1.
- Reject limit (MAX_REJECT=2): mode=1, two rejected completions -> err=1, err_code=2, exactly 2 core_start pulses, done=0.
- Timeout (TIMEOUT_CYCLES=16): mode=2, no core_done -> core_abort pulse once ~16 cycles after core_start; err_code=3. clr_status then clears err/err_code (and irq if MLDSA_IRQ_EN).
- Bad mode / overrun: start with mode=3 -> err_code=1, no core_start. During a valid run, a second start_pulse with mode=0 -> ignored; core_mode unchanged.
- Reset mid-RUN: resetn low for 1 cycle -> all outputs 0 immediately, state IDLE; a subsequent start runs normally.
